// File: rtl/program_loader_pkg.sv
// Shared types and default sizing for the program loader and its staging buffer.
package program_loader_pkg;

  localparam int DEPTH_DEF   = 16;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 16;
  localparam int ADDR_W      = $clog2(DEPTH_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_STREAM,
    ST_DONE,
    ST_ERR
  } state_e;

  // States from which a host start request launches a new image load.
  function automatic logic accepts_start(state_e s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
  endfunction

endpackage

// File: rtl/program_loader_buffer.sv
// Staging register file: synchronous write, asynchronous read, contents never reset.
module prog_buffer
  import program_loader_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PTR_W   = ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/program_loader.sv
// Collects a host program image, then streams it to the control block while
// sequencing the CPU reset and programming-mode flags.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [DATA_W-1:0]      ui_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   read_ui_in,
  input  logic                   done_load,
  output logic                   programming,
  output logic [DATA_W-1:0]      bus_out,
  output logic                   bus_en,
  output logic                   cpu_resetn,
  output logic [$clog2(DEPTH):0] count,
  output logic                   done,
  output logic                   err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TO_W-1:0]  LAST_TO  = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);

  state_e             state_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [TO_W-1:0]    idle_q;
  logic               in_ready_q;
  logic               prog_q;
  logic               done_q;
  logic               err_q;
  logic               hold_q;

  logic               wr_en;
  logic [DATA_W-1:0]  rd_data;

  // in_ready_q is only ever set in FILL, so it doubles as the FILL qualifier.
  assign wr_en = in_ready_q & in_valid;

  prog_buffer #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .PTR_W  (PTR_W)
  ) u_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (ui_in),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      idle_q     <= '0;
      in_ready_q <= 1'b0;
      prog_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start && accepts_start(state_q)) begin
            state_q    <= ST_FILL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            idle_q     <= '0;
            in_ready_q <= 1'b1;
            prog_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            hold_q     <= 1'b1;
          end
        end

        ST_FILL: begin
          if (in_valid) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (wr_ptr_q == LAST_PTR) begin
              // CPU leaves reset in the same cycle it enters programming mode.
              state_q    <= ST_STREAM;
              count_q    <= '0;
              rd_ptr_q   <= '0;
              idle_q     <= '0;
              in_ready_q <= 1'b0;
              hold_q     <= 1'b0;
              prog_q     <= 1'b1;
            end else begin
              count_q <= count_q + CNT_ONE;
            end
          end
        end

        ST_STREAM: begin
          if (done_load) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q  <= count_q + CNT_ONE;
            idle_q   <= '0;
            if (rd_ptr_q == LAST_PTR) begin
              state_q <= ST_DONE;
              prog_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else if (idle_q == LAST_TO) begin
            // TIMEOUT consecutive cycles without a commit: abandon the image.
            state_q <= ST_ERR;
            prog_q  <= 1'b0;
            err_q   <= 1'b1;
            hold_q  <= 1'b1;
          end else begin
            idle_q <= idle_q + TO_ONE;
          end
        end

        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
          prog_q     <= 1'b0;
          done_q     <= 1'b0;
          err_q      <= 1'b0;
          hold_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign programming = prog_q;
  assign done        = done_q;
  assign err         = err_q;
  assign count       = count_q;
  assign bus_out     = rd_data;
  assign bus_en      = read_ui_in & prog_q;
  assign cpu_resetn  = resetn & ~hold_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with an image/commit-level reference model.
module tb_program_loader;

  localparam int DEPTH   = 16;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;

  logic              clk;
  logic              resetn;
  logic              start;
  logic [DATA_W-1:0] ui_in;
  logic              in_valid;
  logic              in_ready;
  logic              read_ui_in;
  logic              done_load;
  logic              programming;
  logic [DATA_W-1:0] bus_out;
  logic              bus_en;
  logic              cpu_resetn;
  logic [4:0]        count;
  logic              done;
  logic              err;

  program_loader #(
    .DEPTH   (DEPTH),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .ui_in       (ui_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .read_ui_in  (read_ui_in),
    .done_load   (done_load),
    .programming (programming),
    .bus_out     (bus_out),
    .bus_en      (bus_en),
    .cpu_resetn  (cpu_resetn),
    .count       (count),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the image contents and how many bytes were
  // accepted / committed, rather than any pointer or state register.
  typedef enum int {M_IDLE, M_FILL, M_STREAM, M_DONE, M_ERR} mode_e;
  mode_e       m_mode = M_IDLE;
  int          m_acc  = 0;
  int          m_com  = 0;
  int          m_idle = 0;
  logic [7:0]  img [DEPTH];

  always @(posedge clk) begin
    if (!resetn) begin
      m_mode = M_IDLE;
      m_acc  = 0;
      m_com  = 0;
      m_idle = 0;
    end else begin
      case (m_mode)
        M_IDLE, M_DONE, M_ERR: begin
          if (start) begin
            m_mode = M_FILL;
            m_acc  = 0;
            m_com  = 0;
          end
        end
        M_FILL: begin
          if (in_valid) begin
            img[m_acc] = ui_in;
            m_acc++;
            if (m_acc == DEPTH) begin
              m_mode = M_STREAM;
              m_com  = 0;
              m_idle = 0;
            end
          end
        end
        M_STREAM: begin
          if (done_load) begin
            m_com++;
            m_idle = 0;
            if (m_com == DEPTH) m_mode = M_DONE;
          end else begin
            m_idle++;
            if (m_idle == TIMEOUT) m_mode = M_ERR;
          end
        end
        default: ;
      endcase
    end
  end

  int exp_count;
  always @(negedge clk) begin
    if (chk_on) begin
      chk("in_ready",    32'(in_ready),    32'(m_mode == M_FILL));
      chk("programming", 32'(programming), 32'(m_mode == M_STREAM));
      chk("done",        32'(done),        32'(m_mode == M_DONE));
      chk("err",         32'(err),         32'(m_mode == M_ERR));
      chk("cpu_resetn",  32'(cpu_resetn),
          32'(resetn && !(m_mode == M_FILL || m_mode == M_ERR)));
      chk("bus_en",      32'(bus_en),      32'(read_ui_in && m_mode == M_STREAM));
      if (m_mode == M_STREAM) chk("bus_out", 32'(bus_out), 32'(img[m_com]));
      exp_count = (m_mode == M_FILL) ? m_acc : (m_mode == M_IDLE) ? 0 : m_com;
      if (m_mode != M_ERR) chk("count", 32'(count), 32'(exp_count));
    end
  end

  // Independent monitors: bytes seen on the bus and cycles with in_ready high.
  logic [7:0] got [$];
  int ir_cnt = 0;
  always @(negedge clk) begin
    if (bus_en === 1'b1) got.push_back(bus_out);
    if (in_ready === 1'b1) ir_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < DEPTH; i++) begin
      ui_in    = 8'(base + 8'(i));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Control-block model: read_ui_in in the 3rd cycle, done_load in the 4th, 7-cycle period.
  task automatic stream(input int n);
    for (int b = 0; b < n; b++) begin
      tick();
      tick();
      read_ui_in = 1'b1;
      tick();
      read_ui_in = 1'b0;
      done_load  = 1'b1;
      tick();
      done_load  = 1'b0;
      tick();
      tick();
      tick();
    end
  endtask

  task automatic chk_stream(input string name, input int base, input logic [7:0] first);
    chk({name, "_len"}, 32'(got.size() - base), 32'(DEPTH));
    if (got.size() - base == DEPTH) begin
      for (int i = 0; i < DEPTH; i++) begin
        chk(name, 32'(got[base + i]), 32'(8'(first + 8'(i))));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base;
  int ir0;
  int k;

  initial begin
    resetn     = 1'b0;
    start      = 1'b1;
    in_valid   = 1'b1;
    ui_in      = 8'h5A;
    read_ui_in = 1'b0;
    done_load  = 1'b0;

    // Reset with start and in_valid held high.
    tick();
    chk_on = 1'b1;
    tick();
    tick();
    chk("rst_cpu_resetn", 32'(cpu_resetn), 32'd0);
    chk("rst_in_ready",   32'(in_ready),   32'd0);
    chk("rst_prog",       32'(programming), 32'd0);
    chk("rst_count",      32'(count),      32'd0);
    resetn   = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("post_rst_cpu_resetn", 32'(cpu_resetn), 32'd1);
    tick();
    chk("idle_in_ready", 32'(in_ready), 32'd0);

    // Continuous fill 0x00..0x0F, then a full stream.
    ir0 = ir_cnt;
    pulse_start();
    fill(8'h00);
    chk("entry_prog",       32'(programming), 32'd1);
    chk("entry_cpu_resetn", 32'(cpu_resetn),  32'd1);
    chk("entry_bus_out",    32'(bus_out),     32'h00);
    chk("entry_count",      32'(count),       32'd0);
    base = got.size();
    stream(DEPTH);
    chk("in_ready_cycles", 32'(ir_cnt - ir0), 32'd16);
    chk("done_flag",  32'(done),        32'd1);
    chk("done_count", 32'(count),       32'd16);
    chk("done_prog",  32'(programming), 32'd0);
    chk_stream("stream_0x00", base, 8'h00);

    // Gappy fill: valid on every third cycle, junk data otherwise.
    pulse_start();
    k = 0;
    for (int c = 0; c < 100 && k < DEPTH; c++) begin
      in_valid = (c % 3 == 0);
      ui_in    = in_valid ? 8'(8'hA0 + 8'(k)) : 8'hEE;
      tick();
      if (c % 3 == 0) k++;
    end
    in_valid = 1'b0;
    chk("gappy_fill_len", 32'(k), 32'd16);
    chk("gappy_prog",     32'(programming), 32'd1);
    base = got.size();
    stream(DEPTH);
    chk_stream("stream_0xA0", base, 8'hA0);

    // Timeout: three bytes committed, then done_load withheld.
    pulse_start();
    fill(8'h30);
    stream(3);
    repeat (12) tick();
    chk("to_not_yet_err",  32'(err),         32'd0);
    chk("to_not_yet_prog", 32'(programming), 32'd1);
    tick();
    chk("to_err",        32'(err),         32'd1);
    chk("to_prog",       32'(programming), 32'd0);
    chk("to_cpu_resetn", 32'(cpu_resetn),  32'd0);
    pulse_start();
    chk("restart_err",      32'(err),      32'd0);
    chk("restart_count",    32'(count),    32'd0);
    chk("restart_in_ready", 32'(in_ready), 32'd1);

    // Reset pulse during the read window of byte 7.
    fill(8'h60);
    stream(7);
    chk("pre_rst_count", 32'(count), 32'd7);
    tick();
    tick();
    read_ui_in = 1'b1;
    #1;
    chk("pre_rst_bus_out", 32'(bus_out), 32'h67);
    resetn = 1'b0;
    tick();
    read_ui_in = 1'b0;
    resetn     = 1'b1;
    #1;
    chk("mid_rst_prog",       32'(programming), 32'd0);
    chk("mid_rst_cpu_resetn", 32'(cpu_resetn),  32'd1);
    chk("mid_rst_in_ready",   32'(in_ready),    32'd0);
    for (int i = 0; i < 3; i++) begin
      done_load = 1'b1;
      tick();
      done_load = 1'b0;
      tick();
    end
    chk("ignored_done_count", 32'(count),       32'd0);
    chk("ignored_done_prog",  32'(programming), 32'd0);
    tick();
    tick();

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Host-facing program loader that sits directly upstream of the control block and RAM data path. It collects a full program image of DEPTH bytes from the host into a staging buffer while holding the CPU in reset, then releases the CPU with `programming` asserted. It drives each byte onto the bus in lockstep with the control block's `read_ui_in` / `done_load` strobes. Once the last byte is written, it drops `programming` so the CPU starts execution from address 0.

## Interface
- DEPTH, 16: program bytes per image (RAM size)
- DATA_W, 8: byte width
- TIMEOUT, 16: max cycles in STREAM between consecutive `done_load` pulses

- clk  in  1  system clock; all state changes on rising edge
- resetn  in  1  synchronous, active-low reset
- start  in  1  begin load when sampled high in IDLE, DONE or ERR
- ui_in  in  DATA_W  host byte
- in_valid  in  1  host byte present
- in_ready  out  1  loader accepts byte; transfer = in_valid & in_ready at rising edge
- read_ui_in  in  1  control block request for a bus byte
- done_load  in  1  control block has committed current byte to RAM
- programming  out  1  CPU is in programming mode
- bus_out  out  DATA_W  byte driven to the data bus
- bus_en  out  1  bus_out valid; only when read_ui_in & programming
- cpu_resetn  out  1  active-low reset to PC and control block
- count  out  $clog2(DEPTH)+1  bytes accepted in FILL, or bytes committed in STREAM/DONE
- done  out  1  image fully committed
- err  out  1  stream timeout occurred

## Operation
- States: IDLE, FILL, STREAM, DONE, ERR.
- IDLE: `in_ready` is 0 and `cpu_resetn` is 1. `start` moves the block to FILL, clearing write pointer, read pointer and `count`.
- FILL:
  - `in_ready` is 1 and `cpu_resetn` is 0.
  - Each transfer writes `buf[wr_ptr]`, then increments `wr_ptr` and `count`.
  - Gaps in `in_valid` are allowed; byte order is preserved.
  - On the transfer of byte DEPTH-1, the next state is STREAM, `count` resets to 0 and `in_ready` drops.
- STREAM:
  - `programming` is 1 and `cpu_resetn` is 1.
  - `bus_out` = `buf[rd_ptr]`, combinational.
  - `bus_en` = `read_ui_in`.
  - A sampled `done_load` increments `rd_ptr` and `count` and clears the timeout counter.
  - The `done_load` with `rd_ptr` = DEPTH-1 moves the block to DONE.
  - A timeout counter reaching TIMEOUT without a `done_load` moves the block to ERR.
- DONE: `programming` is 0, `cpu_resetn` is 1, `done` is 1 and `count` = DEPTH. `start` begins a new FILL.
- ERR: `programming` is 0, `cpu_resetn` is 0 (CPU held) and `err` is 1. `start` begins a new FILL and clears `err`.
- `start` is ignored in FILL and STREAM.
- `read_ui_in` and `done_load` are ignored outside STREAM.
- Pointers are ADDR_W = $clog2(DEPTH) bits and wrap naturally. The exit decision uses the pointer value, not wrap.
- Buffer contents are not reset.

## Timing
- Reset values:
  - state IDLE
  - `programming` 0, `bus_en` 0, `bus_out` = buf[0] (don't-care)
  - `in_ready` 0, `done` 0, `err` 0, `count` 0
  - `cpu_resetn` 0 while `resetn` is low, then 1
- `cpu_resetn` = `resetn` & state-derived value, so loader reset propagates to the CPU in the same cycle.
- FILL→STREAM: `programming` and `cpu_resetn` rise in the same cycle. The CPU therefore leaves reset already in programming mode, with PC = 0.
- `done_load` for the last byte is sampled at rising edge N. `programming` is 0 from cycle N+1, before the next fetch T2.
- `bus_out` advances one cycle after each `done_load`. It is stable throughout every `read_ui_in` window.
- Timeout: counter increments every STREAM cycle and is cleared on entry to STREAM and on `done_load`. ERR is entered on the cycle the counter equals TIMEOUT.
- Reset asserted mid-FILL or mid-STREAM: the next cycle is IDLE with `programming` 0. Any partial image is discarded.

## Structure
- Package `program_loader_pkg`:
  - state enum (IDLE, FILL, STREAM, DONE, ERR)
  - DEPTH and DATA_W defaults
  - derived ADDR_W
- Sub-module `prog_buffer`: DEPTH×DATA_W register file with synchronous write port (we, waddr, wdata) and asynchronous read port (raddr, rdata).
- Top level holds the FSM, both pointers, the timeout counter and output decode.

## Test plan
- Reset with in_valid=1 and start=1 → IDLE; `in_ready`=0, `programming`=0, `cpu_resetn`=0 during reset and 1 after; `count`=0.
- `start` pulse, then 16 continuous bytes 0x00..0x0F → `in_ready` high for exactly 16 cycles and `cpu_resetn`=0 throughout. The next cycle shows `programming`=1, `cpu_resetn`=1, `bus_out`=0x00.
- Model the control block: `read_ui_in` at T3 and `done_load` at T4 every 7 cycles → `bus_en` mirrors `read_ui_in` and `bus_out` steps 0x00..0x0F. `programming`=0 the cycle after the 16th `done_load`; then `done`=1, `count`=16.
- FILL with in_valid toggling 1,0,0,1,… and data 0xA0+i → only handshaked bytes are stored. The streamed sequence is 0xA0..0xAF with no duplicates.
- STREAM with `done_load` withheld for 16 cycles after byte 3 → ERR, `err`=1, `programming`=0, `cpu_resetn`=0. A `start` pulse then re-enters FILL with `err`=0 and `count`=0.
- `resetn` low for one cycle during STREAM byte 7 → IDLE next cycle, `programming`=0; `done_load` pulses afterwards leave `count` at 0.
